sram_port_arbiter: RTL and testbench

// Shares one single-ported, 1-cycle-latency unified SRAM between the IF-stage fetch port and the
// EXE/MEM data port. Sits between mycpu_top's inst/data sram interfaces and the memory.

---
 rtl/sram_port_arbiter.sv | 55 +++++
 tb/tb_sram_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one 1-cycle-latency SRAM between fetch and data ports, data-first with anti-starvation
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;
  logic       resp_valid;
  owner_t     resp_owner;
  logic       grant_data, grant_inst;
  // grants are forced low while reset is held so nothing reaches the SRAM
  assign grant_data   = ~reset & data_req & ~(inst_req & (starve_cnt == LIM));
  assign grant_inst   = ~reset & inst_req & ~grant_data;
  assign sram_en      = grant_inst | grant_data;
  assign sram_wen     = grant_data ? data_wen : 4'h0;
  assign sram_addr    = grant_data ? data_addr : inst_addr;
  assign sram_wdata   = data_wdata;
  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_data_ok = resp_valid & (resp_owner == OWN_INST);
  assign data_data_ok = resp_valid & (resp_owner == OWN_DATA);
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
      resp_valid <= 1'b0;
      resp_owner <= OWN_INST;
    end else begin
      starve_cnt <= (~inst_req | grant_inst) ? 4'd0 : (starve_cnt == LIM) ? LIM : starve_cnt + 4'd1;
      resp_valid <= sram_en;
      if (sram_en) resp_owner <= grant_data ? OWN_DATA : OWN_INST;
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of the SRAM port arbiter against a behavioural SRAM
module tb_sram_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  sram_port_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_en) begin
      sram_rdata <= mem[sram_addr[11:2]];
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) mem[sram_addr[11:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [3:0] w, input logic [31:0] da, input logic [31:0] wd);
    @(negedge clk);
    inst_req = ir; inst_addr = ia; data_req = dr; data_wen = w; data_addr = da; data_wdata = wd;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b1, 32'hBFC00000, 1'b1, 4'hF, 32'h100, 32'h0);
    checks++;
    if ({inst_addr_ok, data_addr_ok, sram_en, sram_wen, inst_data_ok, data_data_ok} !== 9'b0) begin
      errors++;
      $display("FAIL reset outputs got %b want 0", {inst_addr_ok, data_addr_ok, sram_en, sram_wen, inst_data_ok, data_data_ok});
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if ({sram_en, inst_data_ok, data_data_ok} !== 3'b0) begin
      errors++;
      $display("FAIL post_reset got %b want 000", {sram_en, inst_data_ok, data_data_ok});
    end
  endtask

  task automatic test_inst_only;
    for (int k = 0; k < 5; k++) begin
      drive(k < 4, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0);
      checks++;
      if ({inst_addr_ok, data_addr_ok, sram_en} !== {k < 4, 1'b0, k < 4}) begin
        errors++;
        $display("FAIL inst_grant c%0d got %b", k, {inst_addr_ok, data_addr_ok, sram_en});
      end
      checks++;
      if (k < 4 && (sram_addr !== 32'hBFC00000 || sram_wen !== 4'h0)) begin
        errors++;
        $display("FAIL inst_sram c%0d addr %h wen %h want bfc00000 0", k, sram_addr, sram_wen);
      end
      checks++;
      if ({inst_data_ok, data_data_ok} !== {k > 0, 1'b0}) begin
        errors++;
        $display("FAIL inst_data_ok c%0d got %b want %b", k, {inst_data_ok, data_data_ok}, {k > 0, 1'b0});
      end
      if (k > 0) begin
        checks++;
        if (inst_rdata !== 32'hA0000000) begin
          errors++;
          $display("FAIL inst_rdata c%0d got %h want a0000000", k, inst_rdata);
        end
      end
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (inst_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL inst_tail got %b want 0", inst_data_ok);
    end
  endtask

  task automatic test_store_load;
    drive(1'b0, 32'h0, 1'b1, 4'hF, 32'h100, 32'h12345678);
    checks++;
    if ({data_addr_ok, sram_en, sram_wen} !== 6'b11_1111 || sram_addr !== 32'h100 || sram_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL store_issue got ok=%b wen=%h addr=%h wd=%h", data_addr_ok, sram_wen, sram_addr, sram_wdata);
    end
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0);
    checks++;
    if ({data_addr_ok, data_data_ok, inst_data_ok, sram_wen} !== 7'b110_0000) begin
      errors++;
      $display("FAIL load_issue got %b want 1100000", {data_addr_ok, data_data_ok, inst_data_ok, sram_wen});
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL load_data got ok=%b rdata=%h want 1 12345678", data_data_ok, data_rdata);
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (data_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL store_load_tail got %b want 0", data_data_ok);
    end
  endtask

  task automatic test_contention;
    logic [9:0] pat = 10'b1110111011;
    logic prev_d = 1'b0;
    logic prev_g = 1'b0;
    for (int k = 0; k < 11; k++) begin
      drive(k < 10, 32'hBFC00000, k < 10, 4'h0, 32'h300, 32'h0);
      if (k < 10) begin
        checks++;
        if ({data_addr_ok, inst_addr_ok} !== {pat[9-k], ~pat[9-k]}) begin
          errors++;
          $display("FAIL contention_grant c%0d got d=%b i=%b want d=%b", k, data_addr_ok, inst_addr_ok, pat[9-k]);
        end
        checks++;
        if (dut.starve_cnt > 4'd3) begin
          errors++;
          $display("FAIL starve_cnt c%0d got %0d want <=3", k, dut.starve_cnt);
        end
      end
      if (k > 0) begin
        checks++;
        if ({data_data_ok, inst_data_ok} !== {prev_d, ~prev_d} || (prev_g && sram_rdata !== (prev_d ? 32'hA00000C0 : 32'hA0000000))) begin
          errors++;
          $display("FAIL contention_resp c%0d got d=%b i=%b rd=%h want d=%b", k, data_data_ok, inst_data_ok, sram_rdata, prev_d);
        end
      end
      if (k < 10) begin
        prev_d = pat[9-k];
        prev_g = 1'b1;
      end
    end
  endtask

  task automatic test_byte_store;
    drive(1'b0, 32'h0, 1'b1, 4'b0010, 32'h200, 32'h0000EE00);
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'hAABBEEDD) begin
      errors++;
      $display("FAIL byte_store got ok=%b rdata=%h want 1 aabbeedd", data_data_ok, data_rdata);
    end
  endtask

  task automatic test_reset_midflight;
    drive(1'b1, 32'hBFC00000, 1'b1, 4'h0, 32'h100, 32'h0);
    drive(1'b1, 32'hBFC00000, 1'b1, 4'h0, 32'h100, 32'h0);
    checks++;
    if (dut.starve_cnt !== 4'd1 || data_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got cnt=%0d dok=%b want 1 1", dut.starve_cnt, data_addr_ok);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({data_data_ok, inst_data_ok, sram_en, inst_addr_ok, data_addr_ok} !== 5'b0 || dut.starve_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_midflight got %b cnt=%0d want 00000 0", {data_data_ok, inst_data_ok, sram_en, inst_addr_ok, data_addr_ok}, dut.starve_cnt);
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if ({data_data_ok, inst_data_ok} !== 2'b00) begin
      errors++;
      $display("FAIL reset_discard got %b want 00", {data_data_ok, inst_data_ok});
    end
    drive(1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (inst_addr_ok !== 1'b1 || inst_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_grant got ok=%b dok=%b want 1 0", inst_addr_ok, inst_data_ok);
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'hA0000000) begin
      errors++;
      $display("FAIL after_reset_data got ok=%b rdata=%h want 1 a0000000", inst_data_ok, inst_rdata);
    end
  endtask

  task automatic test_idle_gaps;
    logic prev = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 32'h0, (k % 2 == 0) && k < 6, 4'h0, 32'h100, 32'h0);
      checks++;
      if ({data_data_ok, inst_data_ok, dut.resp_valid} !== {prev, 1'b0, prev}) begin
        errors++;
        $display("FAIL idle_gap c%0d got %b want %b", k, {data_data_ok, inst_data_ok, dut.resp_valid}, {prev, 1'b0, prev});
      end
      prev = (k % 2 == 0) && k < 6;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA0000000 + i;
    mem[128] = 32'hAABBCCDD;
    sram_rdata = 32'h0;
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0;
    data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    test_reset;
    test_inst_only;
    test_store_load;
    test_contention;
    test_byte_store;
    test_reset_midflight;
    test_idle_gaps;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
